// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
//
// Each cycle the decoded instruction in ID is captured into the EX stage. The
// registered rs/rt operands are patched combinationally with results still in
// flight in EX/MEM and MEM/WB, so the ALU always sees the newest value.
// A load in EX whose destination is read by the instruction in ID raises
// o_stall_id for one cycle; a bubble is loaded and the load moves on.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_hold                     freeze all state (downstream stall)
//   i_change_pc                branch redirect from EX; flush this stage
//   i_id_*                     decoded instruction fields from ID
//   i_exm_* / i_mwb_*          write-back candidates from EX/MEM and MEM/WB
//   o_stall_id                 hold PC and IF/ID (load-use), combinational
//   o_valid, o_data_rs/_rt,    EX-stage instruction presented to the ALU
//   o_imm, o_funct, o_alu_src,
//   o_pc, o_rd, o_reg_write,
//   o_mem_read, o_mem_write
module id_ex_stage #(
    parameter int DWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32,
    parameter int AWIDTH    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_hold,
    input  logic                 i_change_pc,
    input  logic                 i_id_valid,
    input  logic [AWIDTH-1:0]    i_id_rs,
    input  logic [AWIDTH-1:0]    i_id_rt,
    input  logic [AWIDTH-1:0]    i_id_rd,
    input  logic                 i_id_uses_rt,
    input  logic [DWIDTH-1:0]    i_id_data_rs,
    input  logic [DWIDTH-1:0]    i_id_data_rt,
    input  logic [IMM_WIDTH-1:0] i_id_imm,
    input  logic [4:0]           i_id_funct,
    input  logic                 i_id_alu_src,
    input  logic [PC_WIDTH-1:0]  i_id_pc,
    input  logic                 i_id_reg_write,
    input  logic                 i_id_mem_read,
    input  logic                 i_id_mem_write,
    input  logic                 i_exm_reg_write,
    input  logic [AWIDTH-1:0]    i_exm_rd,
    input  logic [DWIDTH-1:0]    i_exm_value,
    input  logic                 i_mwb_reg_write,
    input  logic [AWIDTH-1:0]    i_mwb_rd,
    input  logic [DWIDTH-1:0]    i_mwb_value,
    output logic                 o_stall_id,
    output logic                 o_valid,
    output logic [DWIDTH-1:0]    o_data_rs,
    output logic [DWIDTH-1:0]    o_data_rt,
    output logic [IMM_WIDTH-1:0] o_imm,
    output logic [4:0]           o_funct,
    output logic                 o_alu_src,
    output logic [PC_WIDTH-1:0]  o_pc,
    output logic [AWIDTH-1:0]    o_rd,
    output logic                 o_reg_write,
    output logic                 o_mem_read,
    output logic                 o_mem_write
);

    logic                 valid_q;
    logic [AWIDTH-1:0]    rs_q;
    logic [AWIDTH-1:0]    rt_q;
    logic [AWIDTH-1:0]    rd_q;
    logic [DWIDTH-1:0]    data_rs_q;
    logic [DWIDTH-1:0]    data_rt_q;
    logic [IMM_WIDTH-1:0] imm_q;
    logic [4:0]           funct_q;
    logic                 alu_src_q;
    logic [PC_WIDTH-1:0]  pc_q;
    logic                 reg_write_q;
    logic                 mem_read_q;
    logic                 mem_write_q;

    logic                 load_use;
    logic                 bubble;

    // Load in EX feeding the instruction in ID. A redirect kills the ID
    // instruction anyway, so the stall is suppressed and the flush proceeds.
    always_comb begin
        load_use = valid_q & mem_read_q & (rd_q != '0) & i_id_valid
                   & ((i_id_rs == rd_q) | (i_id_uses_rt & (i_id_rt == rd_q)));
        o_stall_id = load_use & ~i_change_pc;
        bubble     = i_change_pc | o_stall_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            data_rs_q   <= '0;
            data_rt_q   <= '0;
            imm_q       <= '0;
            funct_q     <= '0;
            alu_src_q   <= 1'b0;
            pc_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!i_hold) begin
            if (bubble) begin
                // funct 0 is add, so a bubble can never trigger a redirect
                valid_q     <= 1'b0;
                rs_q        <= '0;
                rt_q        <= '0;
                rd_q        <= '0;
                data_rs_q   <= '0;
                data_rt_q   <= '0;
                imm_q       <= '0;
                funct_q     <= '0;
                alu_src_q   <= 1'b0;
                pc_q        <= '0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end else begin
                valid_q     <= i_id_valid;
                rs_q        <= i_id_rs;
                rt_q        <= i_id_rt;
                rd_q        <= i_id_rd;
                data_rs_q   <= i_id_data_rs;
                data_rt_q   <= i_id_data_rt;
                imm_q       <= i_id_imm;
                funct_q     <= i_id_funct;
                alu_src_q   <= i_id_alu_src;
                pc_q        <= i_id_pc;
                reg_write_q <= i_id_valid & i_id_reg_write;
                mem_read_q  <= i_id_valid & i_id_mem_read;
                mem_write_q <= i_id_valid & i_id_mem_write;
            end
        end
    end

    // EX/MEM holds the younger result, so it takes priority over MEM/WB.
    // Register 0 is hard-wired and never forwarded.
    always_comb begin
        o_data_rs = data_rs_q;
        if (i_exm_reg_write && (i_exm_rd != '0) && (i_exm_rd == rs_q))
            o_data_rs = i_exm_value;
        else if (i_mwb_reg_write && (i_mwb_rd != '0) && (i_mwb_rd == rs_q))
            o_data_rs = i_mwb_value;

        o_data_rt = data_rt_q;
        if (i_exm_reg_write && (i_exm_rd != '0) && (i_exm_rd == rt_q))
            o_data_rt = i_exm_value;
        else if (i_mwb_reg_write && (i_mwb_rd != '0) && (i_mwb_rd == rt_q))
            o_data_rt = i_mwb_value;
    end

    assign o_valid     = valid_q;
    assign o_imm       = imm_q;
    assign o_funct     = funct_q;
    assign o_alu_src   = alu_src_q;
    assign o_pc        = pc_q;
    assign o_rd        = rd_q;
    assign o_reg_write = valid_q & reg_write_q;
    assign o_mem_read  = valid_q & mem_read_q;
    assign o_mem_write = valid_q & mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int PW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold, chg, idv, urt, asrc;
    logic [AW-1:0] rs, rt, rd, exm_rd, mwb_rd;
    logic [DW-1:0] drs, drt, exm_v, mwb_v;
    logic [IW-1:0] imm;
    logic [4:0]    fn;
    logic [PW-1:0] pc;
    logic          rw, mr, mw, exm_rw, mwb_rw;

    logic          o_stall_id, o_valid, o_alu_src, o_reg_write, o_mem_read, o_mem_write;
    logic [DW-1:0] o_data_rs, o_data_rt;
    logic [IW-1:0] o_imm;
    logic [4:0]    o_funct;
    logic [PW-1:0] o_pc;
    logic [AW-1:0] o_rd;

    id_ex_stage #(.DWIDTH(DW), .IMM_WIDTH(IW), .PC_WIDTH(PW), .AWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_hold(hold), .i_change_pc(chg),
        .i_id_valid(idv), .i_id_rs(rs), .i_id_rt(rt), .i_id_rd(rd),
        .i_id_uses_rt(urt), .i_id_data_rs(drs), .i_id_data_rt(drt),
        .i_id_imm(imm), .i_id_funct(fn), .i_id_alu_src(asrc), .i_id_pc(pc),
        .i_id_reg_write(rw), .i_id_mem_read(mr), .i_id_mem_write(mw),
        .i_exm_reg_write(exm_rw), .i_exm_rd(exm_rd), .i_exm_value(exm_v),
        .i_mwb_reg_write(mwb_rw), .i_mwb_rd(mwb_rd), .i_mwb_value(mwb_v),
        .o_stall_id(o_stall_id), .o_valid(o_valid), .o_data_rs(o_data_rs),
        .o_data_rt(o_data_rt), .o_imm(o_imm), .o_funct(o_funct),
        .o_alu_src(o_alu_src), .o_pc(o_pc), .o_rd(o_rd),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hold, chg, idv;
        logic [AW-1:0] rs, rt, rd;
        logic          urt;
        logic [DW-1:0] drs, drt;
        logic [IW-1:0] imm;
        logic [4:0]    fn;
        logic          asrc;
        logic [PW-1:0] pc;
        logic [2:0]    ctl;      // {reg_write, mem_read, mem_write}
        logic          exm_rw;
        logic [AW-1:0] exm_rd;
        logic [DW-1:0] exm_v;
        logic          mwb_rw;
        logic [AW-1:0] mwb_rd;
        logic [DW-1:0] mwb_v;
        logic          e_stall, e_valid;
        logic [DW-1:0] e_drs, e_drt;
        logic [4:0]    e_fn;
        logic [AW-1:0] e_rd;
        logic [2:0]    e_ctl;
        logic [IW-1:0] e_imm;
        logic [PW-1:0] e_pc;
        logic          e_asrc;
    } vec_t;

    localparam int NV = 22;
    vec_t tv [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hold = v.hold; chg = v.chg; idv = v.idv;
        rs = v.rs; rt = v.rt; rd = v.rd; urt = v.urt;
        drs = v.drs; drt = v.drt; imm = v.imm; fn = v.fn; asrc = v.asrc; pc = v.pc;
        {rw, mr, mw} = v.ctl;
        exm_rw = v.exm_rw; exm_rd = v.exm_rd; exm_v = v.exm_v;
        mwb_rw = v.mwb_rw; mwb_rd = v.mwb_rd; mwb_v = v.mwb_v;
    endtask

    task automatic check_outs(input int idx, input vec_t v);
        chk("valid",   idx, 32'(o_valid),   32'(v.e_valid));
        chk("data_rs", idx, 32'(o_data_rs), 32'(v.e_drs));
        chk("data_rt", idx, 32'(o_data_rt), 32'(v.e_drt));
        chk("funct",   idx, 32'(o_funct),   32'(v.e_fn));
        chk("rd",      idx, 32'(o_rd),      32'(v.e_rd));
        chk("ctrl",    idx, 32'({o_reg_write, o_mem_read, o_mem_write}), 32'(v.e_ctl));
        chk("imm",     idx, 32'(o_imm),     32'(v.e_imm));
        chk("pc",      idx, 32'(o_pc),      32'(v.e_pc));
        chk("alu_src", idx, 32'(o_alu_src), 32'(v.e_asrc));
    endtask

    initial begin
        //        hold chg idv rs rt rd urt drs     drt     imm      fn asrc pc      ctl     exm: rw rd val      mwb: rw rd val     | stall valid e_drs    e_drt    fn rd ctl     imm      pc      asrc
        // first load after reset
        tv[0]  = '{0,0,1, 1,2,3,1, 'h11,'h22,'h1234,4,1,'h100,3'b100, 0,0,0,       0,0,0,       0,1,'h11,'h22,4,3,3'b100,'h1234,'h100,1};
        // forwarding priority on rs, then MEM/WB only, then rd=0, then rt
        tv[1]  = '{0,0,1, 3,4,6,1, 'h33,'h44,0,0,0,'h104,3'b100,     1,3,'hAAAA,  1,3,'hBBBB,  0,1,'hAAAA,'h44,0,6,3'b100,0,'h104,0};
        tv[2]  = '{1,0,1, 3,4,6,1, 'h33,'h44,0,0,0,'h104,3'b100,     0,3,'hAAAA,  1,3,'hBBBB,  0,1,'hBBBB,'h44,0,6,3'b100,0,'h104,0};
        tv[3]  = '{1,0,1, 3,4,6,1, 'h33,'h44,0,0,0,'h104,3'b100,     1,0,'hAAAA,  1,0,'hBBBB,  0,1,'h33,'h44,0,6,3'b100,0,'h104,0};
        tv[4]  = '{1,0,1, 3,4,6,1, 'h33,'h44,0,0,0,'h104,3'b100,     1,4,'hCCCC,  1,4,'hDDDD,  0,1,'h33,'hCCCC,0,6,3'b100,0,'h104,0};
        // load-use on rs: lw r5, stall one cycle, bubble, then MEM/WB forward
        tv[5]  = '{0,0,1, 1,8,5,0, 'h10,0,4,0,1,'h108,3'b110,        0,0,0,       0,0,0,       0,1,'h10,0,0,5,3'b110,4,'h108,1};
        tv[6]  = '{0,0,1, 5,2,9,1, 'h55,'h22,0,0,0,'h10C,3'b100,     0,0,0,       0,0,0,       1,0,0,0,0,0,3'b000,0,0,0};
        tv[7]  = '{0,0,1, 5,2,9,1, 'h55,'h22,0,0,0,'h10C,3'b100,     0,0,0,       1,5,'h5000,  0,1,'h5000,'h22,0,9,3'b100,0,'h10C,0};
        // uses_rt gating; stall stays asserted under hold
        tv[8]  = '{0,0,1, 1,2,7,0, 1,2,8,0,1,'h110,3'b110,           0,0,0,       0,0,0,       0,1,1,2,0,7,3'b110,8,'h110,1};
        tv[9]  = '{1,0,1, 1,7,10,0, 3,4,0,0,0,'h114,3'b100,          0,0,0,       0,0,0,       0,1,1,2,0,7,3'b110,8,'h110,1};
        tv[10] = '{1,0,1, 1,7,10,1, 3,4,0,0,0,'h114,3'b100,          0,0,0,       0,0,0,       1,1,1,2,0,7,3'b110,8,'h110,1};
        tv[11] = '{0,0,1, 1,7,10,1, 3,4,0,0,0,'h114,3'b100,          0,0,0,       0,0,0,       1,0,0,0,0,0,3'b000,0,0,0};
        // flush beats a concurrent load-use
        tv[12] = '{0,0,1, 1,0,5,0, 1,0,0,0,1,'h120,3'b110,           0,0,0,       0,0,0,       0,1,1,0,0,5,3'b110,0,'h120,1};
        tv[13] = '{0,1,1, 5,0,12,0, 'h99,0,'h0F,15,0,'h124,3'b100,   0,0,0,       0,0,0,       0,0,0,0,0,0,3'b000,0,0,0};
        // hold with redirect for 3 cycles, then the redirect takes effect
        tv[14] = '{0,0,1, 2,3,4,1, 'h21,'h31,7,3,0,'h130,3'b001,     0,0,0,       0,0,0,       0,1,'h21,'h31,3,4,3'b001,7,'h130,0};
        tv[15] = '{1,1,1, 5,6,8,1, 1,2,0,15,0,'h134,3'b100,          0,0,0,       0,0,0,       0,1,'h21,'h31,3,4,3'b001,7,'h130,0};
        tv[16] = '{1,1,1, 5,6,8,1, 1,2,0,15,0,'h134,3'b100,          0,0,0,       0,0,0,       0,1,'h21,'h31,3,4,3'b001,7,'h130,0};
        tv[17] = '{1,1,1, 5,6,8,1, 1,2,0,15,0,'h134,3'b100,          0,0,0,       0,0,0,       0,1,'h21,'h31,3,4,3'b001,7,'h130,0};
        tv[18] = '{0,1,1, 5,6,8,1, 1,2,0,15,0,'h134,3'b100,          0,0,0,       0,0,0,       0,0,0,0,0,0,3'b000,0,0,0};
        // invalid load clears control but keeps the datapath fields
        tv[19] = '{0,0,0, 1,2,6,0, 'h77,'h88,1,2,1,'h140,3'b111,     0,0,0,       0,0,0,       0,0,'h77,'h88,2,6,3'b000,1,'h140,1};
        // load to r0 never stalls
        tv[20] = '{0,0,1, 0,0,0,0, 0,0,0,0,1,'h144,3'b110,           0,0,0,       0,0,0,       0,1,0,0,0,0,3'b110,0,'h144,1};
        tv[21] = '{0,0,1, 0,0,1,1, 5,6,0,0,0,'h148,3'b100,           0,0,0,       0,0,0,       0,1,5,6,0,1,3'b100,0,'h148,0};

        // reset with random inputs
        rst_n = 1'b0;
        hold = 1'($urandom); chg = 1'($urandom); idv = 1'b1;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); urt = 1'b1;
        drs = $urandom; drt = $urandom; imm = 16'($urandom); fn = 5'($urandom_range(16));
        asrc = 1'b1; pc = $urandom; rw = 1'b1; mr = 1'b1; mw = 1'b1;
        exm_rw = 1'b1; exm_rd = 5'($urandom); exm_v = $urandom;
        mwb_rw = 1'b1; mwb_rd = 5'($urandom); mwb_v = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",   -1, 32'(o_stall_id), 0);
        chk("rst_valid",   -1, 32'(o_valid), 0);
        chk("rst_data_rs", -1, o_data_rs, 0);
        chk("rst_data_rt", -1, o_data_rt, 0);
        chk("rst_funct",   -1, 32'(o_funct), 0);
        chk("rst_rd",      -1, 32'(o_rd), 0);
        chk("rst_ctrl",    -1, 32'({o_reg_write, o_mem_read, o_mem_write}), 0);
        chk("rst_imm",     -1, 32'(o_imm), 0);
        chk("rst_pc",      -1, o_pc, 0);
        chk("rst_alu_src", -1, 32'(o_alu_src), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tv[i]);
            #1;
            chk("stall_id", i, 32'(o_stall_id), 32'(tv[i].e_stall));
            @(posedge clk);
            #1;
            check_outs(i, tv[i]);
            @(negedge clk);
        end

        // asynchronous reset mid-cycle while held
        hold = 1'b1; chg = 1'b0; exm_rw = 1'b0; mwb_rw = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", -2, 32'(o_valid), 0);
        chk("async_rst_pc",    -2, o_pc, 0);
        chk("async_rst_rd",    -2, 32'(o_rd), 0);
        chk("async_rst_data",  -2, o_data_rs, 0);
        chk("async_rst_ctrl",  -2, 32'({o_reg_write, o_mem_read, o_mem_write}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
